dispatch: RTL and testbench
===========================

# dispatch

Dispatch stage between `rename` and the reservation stations / ROB. It accepts one renamed uop per cycle into a one-entry output register and annotates source operands with ready bits from an internal 128-entry physical-register busy table. When the uop reaches the head, dispatch allocates a ROB entry and issues it to the reservation station selected by its `fu` field. CDB wakeups and flush on mispredict are handled in the same stage.

## Interface
- `NUM_PREGS`, default 128: number of physical registers; tag width is 7.
- `ROB_TAG_W`, default 5: ROB tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  rename output valid.
- `data_in`  in  `rename_data`  ps1, ps2, pd_new, pd_old, imm; the `rob_tag` field is ignored.
- `fu_in`  in  2  functional unit: 00 = ROB-only, 01 = ALU, 10 = BRU, 11 = LSU.
- `ready_in`  out  1  dispatch can accept a uop this cycle.
- `rs_ready`  in  3  per-RS space available: [0] ALU, [1] BRU, [2] LSU.
- `rs_valid`  out  3  one-hot issue strobe to the RS.
- `rs_data`  out  `rs_entry`  ps1, ps1_rdy, ps2, ps2_rdy, pd_new, imm, rob_tag.
- `rob_full`  in  1  ROB cannot allocate.
- `rob_tail`  in  5  tag assigned to the next allocation.
- `rob_alloc`  out  1  ROB allocate strobe.
- `rob_pd_new`, `rob_pd_old`  out  7  destination tags for the ROB entry.
- `rob_done`  out  1  the entry is complete at allocation; set when fu = 00.
- `cdb_valid`  in  1  result broadcast valid.
- `cdb_pd`  in  7  physical tag being written back.
- `mispredict`  in  1  flush.

## Operation
- **Output register.** The stage holds `hold_valid` plus the latched uop, fu, ps1_rdy and ps2_rdy.
- **Accept.** `accept = valid_in && ready_in`.
- **ready_in.** `ready_in = reset && !mispredict && (!hold_valid || fire)`.
- **fire.** `fire = hold_valid && !rob_full && (fu==00 || rs_ready[fu-1])`.
- **On fire:**
  - `rob_alloc` = 1.
  - `rs_valid[fu-1]` = 1, unless fu = 00.
  - `rs_data.rob_tag` = `rob_tail`.
  - `rob_done` = (fu==00).
  - These outputs are combinational from the held state and are 0 when not firing.
- **Busy table.** One bit per physical register; p0 is always ready, and writes to p0 are ignored.
  - Set: on fire, if pd_new != 0, `busy[pd_new]` is set.
  - Clear: on `cdb_valid`, `busy[cdb_pd]` is cleared.
  - Same-cycle set and clear of the same tag: the set wins, because the new producer is younger.
- **Ready capture on accept.** `psX_rdy = (psX==0) || (!busy[psX] && !(fire && psX==hold.pd_new)) || (cdb_valid && cdb_pd==psX)`.
  - The fire term forwards the busy bit being set this cycle.
  - The CDB term forwards a wakeup arriving this cycle.
- **Held wakeup.** While held, `cdb_valid && cdb_pd==psX` sets `psX_rdy`. `rs_data` shows the updated bits from the next cycle onward.
- **mispredict.**
  - Clears `hold_valid` at the next edge.
  - Suppresses fire, accept and all strobes in that cycle.
  - The busy table is not restored. Squashed tags are re-set when reallocated and are unreachable after map recovery.
- **Reset.** Applies asynchronously:
  - `hold_valid` = 0.
  - All busy bits = 0.
  - All strobes = 0, `ready_in` = 0 while asserted, `rs_data` = '0.

## Timing
- Latency: a uop accepted at edge N can fire in the cycle following edge N. Minimum rename-to-RS latency is 1 cycle.
- Throughput: 1 uop/cycle when downstream never stalls; accept and fire occur in the same cycle.
- Backpressure: with `rob_full` = 1 or the target `rs_ready` = 0, the uop holds and `ready_in` = 0. Held contents are stable except for the ready bits.
- `mispredict` has priority over `cdb_valid` for the held uop. `cdb_valid` still updates the busy table in a mispredict cycle.
- Reset deassertion: `ready_in` rises combinationally once `reset` is high and `mispredict` = 0.

## Structure
- **`types_pkg` additions:**
  - `rs_entry` struct.
  - FU encodings `FU_NONE`/`FU_ALU`/`FU_BRU`/`FU_LSU`.
  - `PREG_W` = 7.
- **Sub-module `busy_table`:**
  - Ports: `clk`, `reset`, set port (en, tag), clear port (en, tag).
  - Two combinational read ports plus a forward-aware ready output.
  - Implements the p0 and set-wins rules.

## Test plan
- **Independent uop.** After reset, ADDI with ps1=1, ps2=2, pd_new=40, fu=01; `rs_ready`=3'b111, `rob_tail`=3.
  - Expect one cycle later: `rs_valid`=3'b001, ps1_rdy=ps2_rdy=1, rob_tag=3, `rob_alloc`=1, `rob_pd_new`=40, `busy[40]` set.
- **Back-to-back dependent.** Second uop with ps1=40 accepted in the same cycle the first fires.
  - Expect: ps1_rdy=0 on issue.
  - Then `cdb_valid` with `cdb_pd`=40 while a third uop reading 40 is captured: third uop has ps1_rdy=1.
- **Held wakeup under RS stall.** LSU uop held with `rs_ready[2]`=0 and ps2 busy.
  - Expect: `ready_in`=0.
  - CDB on ps2 during the stall: issues with ps2_rdy=1 once `rs_ready[2]`=1.
- **ROB full.** `rob_full`=1 for 3 cycles.
  - Expect: no `rob_alloc` and no `rs_valid` during those cycles; fire in the cycle `rob_full` drops.
- **Mispredict and ROB-only uop.**
  - `mispredict` with a held uop: no strobes, `hold_valid`=0 after the edge, `ready_in`=0 during the pulse.
  - fu=00 uop: `rob_alloc`=1, `rob_done`=1, `rs_valid`=0.
- **Reset mid-stall and p0.**
  - Assert `reset` low asynchronously: all outputs 0 immediately; `busy[40]` clear after release.
  - Uop with pd_new=0: p0 never becomes busy.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the dispatch stage: operand tags, FU encodings,
// and the rename / reservation-station bundles.
package types_pkg;

    localparam int PREG_W = 7;
    localparam int RTAG_W = 5;
    localparam int IMM_W  = 32;

    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic [1:0] {
        FU_NONE = 2'b00,
        FU_ALU  = 2'b01,
        FU_BRU  = 2'b10,
        FU_LSU  = 2'b11
    } fu_e;

    typedef struct packed {
        preg_t             ps1;
        preg_t             ps2;
        preg_t             pd_new;
        preg_t             pd_old;
        logic [IMM_W-1:0]  imm;
        logic [RTAG_W-1:0] rob_tag;
    } rename_data;

    typedef struct packed {
        preg_t             ps1;
        logic              ps1_rdy;
        preg_t             ps2;
        logic              ps2_rdy;
        preg_t             pd_new;
        logic [IMM_W-1:0]  imm;
        logic [RTAG_W-1:0] rob_tag;
    } rs_entry;

    typedef struct packed {
        preg_t            ps1;
        preg_t            ps2;
        preg_t            pd_new;
        preg_t            pd_old;
        logic [IMM_W-1:0] imm;
        fu_e              fu;
        logic             ps1_rdy;
        logic             ps2_rdy;
    } held_t;

    // RS strobe bit for each FU; ROB-only uops target no RS.
    function automatic logic [2:0] fu_onehot(input fu_e fu);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (fu)
            FU_NONE: oh = 3'b000;
            FU_ALU:  oh = 3'b001;
            FU_BRU:  oh = 3'b010;
            FU_LSU:  oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dispatch_busy_table.sv
// Physical-register busy bits with two forward-aware ready read ports.
// p0 is hard-wired ready; a same-cycle set beats a clear of the same tag.
module busy_table
    import types_pkg::*;
#(
    parameter int NUM_PREGS = 128
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  set_en,
    input  preg_t set_tag,
    input  logic  clr_en,
    input  preg_t clr_tag,
    input  preg_t rd1_tag,
    input  preg_t rd2_tag,
    output logic  rd1_rdy,
    output logic  rd2_rdy
);

    logic [NUM_PREGS-1:0] busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (clr_en && clr_tag != '0)
                busy[clr_tag] <= 1'b0;
            // Later assignment wins: the new producer is younger.
            if (set_en && set_tag != '0)
                busy[set_tag] <= 1'b1;
        end
    end

    always_comb begin
        rd1_rdy = (rd1_tag == '0)
               || (!busy[rd1_tag] && !(set_en && rd1_tag == set_tag))
               || (clr_en && clr_tag == rd1_tag);
        rd2_rdy = (rd2_tag == '0)
               || (!busy[rd2_tag] && !(set_en && rd2_tag == set_tag))
               || (clr_en && clr_tag == rd2_tag);
    end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: one-entry output register between rename and the
// RS/ROB, with operand ready tracking, CDB wakeup and mispredict flush.
module dispatch
    import types_pkg::*;
#(
    parameter int NUM_PREGS = 128,
    parameter int ROB_TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  rename_data           data_in,
    input  logic [1:0]           fu_in,
    output logic                 ready_in,
    input  logic [2:0]           rs_ready,
    output logic [2:0]           rs_valid,
    output rs_entry              rs_data,
    input  logic                 rob_full,
    input  logic [ROB_TAG_W-1:0] rob_tail,
    output logic                 rob_alloc,
    output preg_t                rob_pd_new,
    output preg_t                rob_pd_old,
    output logic                 rob_done,
    input  logic                 cdb_valid,
    input  preg_t                cdb_pd,
    input  logic                 mispredict
);

    held_t h;
    logic  h_valid;
    logic  fu_ok;
    logic  fire;
    logic  accept;
    logic  rdy1;
    logic  rdy2;

    always_comb begin
        fu_ok    = (h.fu == FU_NONE) || (|(fu_onehot(h.fu) & rs_ready));
        fire     = h_valid && !mispredict && !rob_full && fu_ok;
        ready_in = reset && !mispredict && (!h_valid || fire);
        accept   = valid_in && ready_in;
    end

    busy_table #(
        .NUM_PREGS(NUM_PREGS)
    ) u_busy (
        .clk     (clk),
        .reset   (reset),
        .set_en  (fire),
        .set_tag (h.pd_new),
        .clr_en  (cdb_valid),
        .clr_tag (cdb_pd),
        .rd1_tag (data_in.ps1),
        .rd2_tag (data_in.ps2),
        .rd1_rdy (rdy1),
        .rd2_rdy (rdy2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_valid <= 1'b0;
            h       <= '0;
        end else if (mispredict) begin
            h_valid <= 1'b0;
        end else if (accept) begin
            h_valid <= 1'b1;
            h       <= '{ps1:     data_in.ps1,
                         ps2:     data_in.ps2,
                         pd_new:  data_in.pd_new,
                         pd_old:  data_in.pd_old,
                         imm:     data_in.imm,
                         fu:      fu_e'(fu_in),
                         ps1_rdy: rdy1,
                         ps2_rdy: rdy2};
        end else begin
            if (fire)
                h_valid <= 1'b0;
            if (cdb_valid && cdb_pd == h.ps1)
                h.ps1_rdy <= 1'b1;
            if (cdb_valid && cdb_pd == h.ps2)
                h.ps2_rdy <= 1'b1;
        end
    end

    always_comb begin
        rs_valid   = 3'b000;
        rs_data    = '0;
        rob_alloc  = 1'b0;
        rob_done   = 1'b0;
        rob_pd_new = '0;
        rob_pd_old = '0;
        if (h_valid) begin
            rs_data.ps1     = h.ps1;
            rs_data.ps1_rdy = h.ps1_rdy;
            rs_data.ps2     = h.ps2;
            rs_data.ps2_rdy = h.ps2_rdy;
            rs_data.pd_new  = h.pd_new;
            rs_data.imm     = h.imm;
        end
        if (fire) begin
            rob_alloc       = 1'b1;
            rs_valid        = fu_onehot(h.fu);
            rob_done        = (h.fu == FU_NONE);
            rob_pd_new      = h.pd_new;
            rob_pd_old      = h.pd_old;
            rs_data.rob_tag = rob_tail;
        end
    end

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: vector stream plus corner sequences.
module tb_dispatch;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    rename_data data_in;
    logic [1:0] fu_in;
    logic       ready_in;
    logic [2:0] rs_ready;
    logic [2:0] rs_valid;
    rs_entry    rs_data;
    logic       rob_full;
    logic [4:0] rob_tail = 5'd3;
    logic       rob_alloc;
    preg_t      rob_pd_new;
    preg_t      rob_pd_old;
    logic       rob_done;
    logic       cdb_valid;
    preg_t      cdb_pd;
    logic       mispredict;

    dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .fu_in      (fu_in),
        .ready_in   (ready_in),
        .rs_ready   (rs_ready),
        .rs_valid   (rs_valid),
        .rs_data    (rs_data),
        .rob_full   (rob_full),
        .rob_tail   (rob_tail),
        .rob_alloc  (rob_alloc),
        .rob_pd_new (rob_pd_new),
        .rob_pd_old (rob_pd_old),
        .rob_done   (rob_done),
        .cdb_valid  (cdb_valid),
        .cdb_pd     (cdb_pd),
        .mispredict (mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        preg_t       ps1;
        preg_t       ps2;
        preg_t       pd_new;
        preg_t       pd_old;
        logic [31:0] imm;
        fu_e         fu;
        logic        cdb_v;
        preg_t       cdb_p;
        logic        r1;
        logic        r2;
    } vec_t;

    typedef struct {
        rs_entry e;
        fu_e     fu;
        preg_t   pd_old;
    } exp_t;

    exp_t    sb[$];
    exp_t    sx;
    rs_entry sw;
    int      total = 0;
    int      bad = 0;
    vec_t    vt[10];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int d,
                                input int o, input fu_e f, input logic cv,
                                input int cp, input logic r1, input logic r2);
        vec_t v;
        v.ps1    = preg_t'(a);
        v.ps2    = preg_t'(b);
        v.pd_new = preg_t'(d);
        v.pd_old = preg_t'(o);
        v.imm    = 32'h1000 + 32'(d);
        v.fu     = f;
        v.cdb_v  = cv;
        v.cdb_p  = preg_t'(cp);
        v.r1     = r1;
        v.r2     = r2;
        return v;
    endfunction

    function automatic logic [2:0] want_valid(input fu_e f);
        case (f)
            FU_ALU:  return 3'b001;
            FU_BRU:  return 3'b010;
            FU_LSU:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        valid_in = 1'b1;
        data_in  = '{ps1: v.ps1, ps2: v.ps2, pd_new: v.pd_new,
                     pd_old: v.pd_old, imm: v.imm, rob_tag: 5'h1f};
        fu_in     = v.fu;
        cdb_valid = v.cdb_v;
        cdb_pd    = v.cdb_p;
    endtask

    task automatic push(input vec_t v);
        exp_t x;
        x.e = '{ps1: v.ps1, ps1_rdy: v.r1, ps2: v.ps2, ps2_rdy: v.r2,
                pd_new: v.pd_new, imm: v.imm, rob_tag: 5'd0};
        x.fu     = v.fu;
        x.pd_old = v.pd_old;
        sb.push_back(x);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input bit do_push);
        bit ok;
        ok = 1'b0;
        drive(v);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready_in) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: ready_in never rose for pd %0d", v.pd_new);
        end else if (do_push) begin
            push(v);
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        cdb_valid = 1'b0;
    endtask

    // Scoreboard: every ROB allocation must match the oldest expected uop.
    always @(negedge clk) begin
        if (rob_alloc) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexp_alloc: got alloc pd %0d expected none", rob_pd_new);
            end else begin
                sx = sb.pop_front();
                sw = sx.e;
                sw.rob_tag = rob_tail;
                check("rs_data", 64'(rs_data), 64'(sw));
                check("rs_valid", 64'(rs_valid), 64'(want_valid(sx.fu)));
                check("rob_pd_new", 64'(rob_pd_new), 64'(sx.e.pd_new));
                check("rob_pd_old", 64'(rob_pd_old), 64'(sx.pd_old));
                check("rob_done", 64'(rob_done), 64'(sx.fu == FU_NONE));
                rob_tail = rob_tail + 5'd1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(1, 2, 40, 8, FU_ALU, 0, 0, 1, 1);
        vt[1] = mk(40, 0, 41, 9, FU_BRU, 0, 0, 0, 1);
        vt[2] = mk(40, 41, 42, 10, FU_LSU, 1, 40, 1, 0);
        vt[3] = mk(41, 42, 43, 11, FU_ALU, 0, 0, 0, 0);
        vt[4] = mk(40, 0, 0, 0, FU_NONE, 0, 0, 1, 1);
        vt[5] = mk(43, 5, 44, 12, FU_ALU, 1, 43, 1, 1);
        vt[6] = mk(44, 0, 45, 13, FU_BRU, 1, 44, 1, 1);
        vt[7] = mk(44, 45, 46, 14, FU_LSU, 0, 0, 0, 0);
        vt[8] = mk(0, 0, 0, 0, FU_NONE, 0, 0, 1, 1);
        vt[9] = mk(0, 46, 47, 15, FU_ALU, 1, 46, 1, 1);

        reset      = 1'b1;
        valid_in   = 1'b0;
        data_in    = '0;
        fu_in      = 2'b00;
        rs_ready   = 3'b111;
        rob_full   = 1'b0;
        cdb_valid  = 1'b0;
        cdb_pd     = '0;
        mispredict = 1'b0;
        #2 reset = 1'b0;
        #10;
        check("reset_ready_in", 64'(ready_in), 64'd0);
        check("reset_alloc", 64'({rob_alloc, rs_valid}), 64'd0);
        #5 reset = 1'b1;
        @(negedge clk);
        check("release_ready_in", 64'(ready_in), 64'd1);
        @(posedge clk);
        #1;

        // Streaming with no backpressure: one accept and one fire per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i]);
            @(negedge clk);
            check("stream_ready_in", 64'(ready_in), 64'd1);
            if (i > 0)
                check("stream_fire", 64'(rob_alloc), 64'd1);
            push(vt[i]);
            @(posedge clk);
            #1;
        end
        valid_in  = 1'b0;
        cdb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stream_drain", 64'(sb.size()), 64'd0);

        // Held wakeup under LSU stall.
        rs_ready = 3'b011;
        send(mk(0, 41, 48, 16, FU_LSU, 0, 0, 1, 1), 1'b1);
        @(negedge clk);
        check("stall_ready_in", 64'(ready_in), 64'd0);
        check("stall_alloc", 64'(rob_alloc), 64'd0);
        check("stall_rdy2_pre", 64'(rs_data.ps2_rdy), 64'd0);
        @(posedge clk);
        #1;
        cdb_valid = 1'b1;
        cdb_pd    = 7'd41;
        @(negedge clk);
        check("stall_rdy2_same", 64'(rs_data.ps2_rdy), 64'd0);
        @(posedge clk);
        #1;
        cdb_valid = 1'b0;
        @(negedge clk);
        check("stall_rdy2_post", 64'(rs_data.ps2_rdy), 64'd1);
        check("stall_alloc2", 64'(rob_alloc), 64'd0);
        @(posedge clk);
        #1;
        rs_ready = 3'b111;
        @(negedge clk);
        check("stall_release_fire", 64'(rob_alloc), 64'd1);
        @(posedge clk);
        #1;

        // ROB full for three cycles.
        rob_full = 1'b1;
        send(mk(0, 0, 49, 17, FU_ALU, 0, 0, 1, 1), 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("full_strobes", 64'({rob_alloc, rs_valid}), 64'd0);
            check("full_ready_in", 64'(ready_in), 64'd0);
            @(posedge clk);
            #1;
        end
        rob_full = 1'b0;
        @(negedge clk);
        check("full_drop_fire", 64'(rob_alloc), 64'd1);
        @(posedge clk);
        #1;

        // Mispredict flushes a held uop that would otherwise fire.
        rob_full = 1'b1;
        send(mk(0, 0, 50, 18, FU_ALU, 0, 0, 1, 1), 1'b0);
        @(negedge clk);
        check("mp_held_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk);
        #1;
        rob_full   = 1'b0;
        mispredict = 1'b1;
        drive(mk(0, 0, 54, 19, FU_BRU, 0, 0, 1, 1));
        @(negedge clk);
        check("mp_ready_in", 64'(ready_in), 64'd0);
        check("mp_strobes", 64'({rob_alloc, rs_valid, rob_done}), 64'd0);
        @(posedge clk);
        #1;
        mispredict = 1'b0;
        valid_in   = 1'b0;
        @(negedge clk);
        check("mp_empty_ready_in", 64'(ready_in), 64'd1);
        check("mp_empty_alloc", 64'(rob_alloc), 64'd0);
        @(posedge clk);
        #1;

        // ROB-only uop reading a still-busy tag.
        send(mk(48, 0, 51, 20, FU_NONE, 0, 0, 0, 1), 1'b1);
        @(negedge clk);
        check("rob_only_fire", 64'(rob_alloc), 64'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset during a firing cycle.
        send(mk(0, 0, 40, 21, FU_ALU, 0, 0, 1, 1), 1'b1);
        rs_ready = 3'b011;
        send(mk(40, 0, 53, 22, FU_LSU, 0, 0, 0, 1), 1'b0);
        @(negedge clk);
        check("pre_reset_rdy1", 64'(rs_data.ps1_rdy), 64'd0);
        @(posedge clk);
        #1;
        rs_ready = 3'b111;
        #2;
        check("pre_reset_fire", 64'(rob_alloc), 64'd1);
        reset = 1'b0;
        #1;
        check("reset_outs", 64'({ready_in, rob_alloc, rs_valid, rob_done,
                                 rob_pd_new, rob_pd_old}), 64'd0);
        check("reset_rs_data", 64'(rs_data), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(negedge clk);
        check("rerelease_ready_in", 64'(ready_in), 64'd1);
        @(posedge clk);
        #1;
        send(mk(40, 0, 52, 23, FU_ALU, 0, 0, 1, 1), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("final_drain", 64'(sb.size()), 64'd0);
        check("p0_never_busy", 64'(dut.u_busy.busy[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
